fetch_pc_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer directly downstream of the branch unit. Holds the architectural PC, drives it to the branch unit's PC input and to instruction memory, and presents the fetched instruction to decode. Loads the branch unit's next-PC result on each commit, then fetches from that address. Instruction memory has variable latency and a req/ack handshake.

---
 rtl/fetch_pc_unit.sv | 99 +++++++++
 tb/tb_fetch_pc_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch sequencer (BOOT -> FETCH -> READY) with req/ack imem handshake.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_pc_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pcNext,
    input  logic                  commit,
    output logic [ADDR_WIDTH-1:0] pcOut,
    output logic                  imemReq,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    input  logic                  imemAck,
    input  logic [INSN_WIDTH-1:0] imemData,
    output logic [INSN_WIDTH-1:0] insnOut,
    output logic                  insnValid,
    output logic                  misalign
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perfFetchCnt,
    output logic [31:0]           perfStallCnt
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pcAligned;
    logic                    pcMisaligned;

    assign pcAligned    = pcNext & ALIGN_MASK;
    assign pcMisaligned = |(pcNext & ~ALIGN_MASK);
    assign imemAddr     = pcOut;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pcOut     <= RESET_PC;
            insnOut   <= '0;
            insnValid <= 1'b0;
            imemReq   <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= FETCH;
                    imemReq <= 1'b1;
                end
                FETCH: begin
                    if (imemAck) begin
                        insnOut   <= imemData;
                        insnValid <= 1'b1;
                        imemReq   <= 1'b0;
                        state     <= READY;
                    end
                end
                READY: begin
                    if (commit) begin
                        // Misaligned targets are truncated to the word boundary and still fetched.
                        pcOut     <= pcAligned;
                        insnValid <= 1'b0;
                        imemReq   <= 1'b1;
                        state     <= FETCH;
                        if (pcMisaligned)
                            misalign <= 1'b1;
                    end
                end
                default: begin
                    state   <= BOOT;
                    imemReq <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfFetchCnt <= '0;
            perfStallCnt <= '0;
        end else if (state == FETCH) begin
            if (imemAck)
                perfFetchCnt <= perfFetchCnt + 32'd1;
            else
                perfStallCnt <= perfStallCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; inputs driven and outputs sampled on the falling edge.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcNext;
    logic        commit;
    logic [31:0] pcOut;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] insnOut;
    logic        insnValid;
    logic        misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetchCnt;
    logic [31:0] perfStallCnt;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .ADDR_WIDTH(32),
        .INSN_WIDTH(32),
        .RESET_PC  (32'h0),
        .ALIGN_BITS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pcNext   (pcNext),
        .commit   (commit),
        .pcOut    (pcOut),
        .imemReq  (imemReq),
        .imemAddr (imemAddr),
        .imemAck  (imemAck),
        .imemData (imemData),
        .insnOut  (insnOut),
        .insnValid(insnValid),
        .misalign (misalign)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perfFetchCnt(perfFetchCnt),
        .perfStallCnt(perfStallCnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; commit = 1'b0; pcNext = '0; imemAck = 1'b0; imemData = '0;
        @(negedge clk);
        checks++; if (pcOut !== 32'h0)     begin fails++; $display("FAIL rst_pc got %h want %h", pcOut, 32'h0); end
        checks++; if (imemReq !== 1'b0)    begin fails++; $display("FAIL rst_req got %b want 0", imemReq); end
        checks++; if (insnValid !== 1'b0)  begin fails++; $display("FAIL rst_valid got %b want 0", insnValid); end
        checks++; if (insnOut !== 32'h0)   begin fails++; $display("FAIL rst_insn got %h want 0", insnOut); end
        checks++; if (misalign !== 1'b0)   begin fails++; $display("FAIL rst_misalign got %b want 0", misalign); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perfFetchCnt !== 32'd0 || perfStallCnt !== 32'd0) begin fails++; $display("FAIL rst_perf got %0d/%0d want 0/0", perfFetchCnt, perfStallCnt); end
`endif
        // Release into BOOT with a commit that must be ignored.
        rst = 1'b0; commit = 1'b1; pcNext = 32'h204;
        #1;
        checks++; if (imemReq !== 1'b0) begin fails++; $display("FAIL boot_req got %b want 0", imemReq); end
        tick();
        commit = 1'b0;
        checks++; if (imemReq !== 1'b1)       begin fails++; $display("FAIL first_req got %b want 1", imemReq); end
        checks++; if (imemAddr !== 32'h0)     begin fails++; $display("FAIL first_addr got %h want 0", imemAddr); end
        checks++; if (pcOut !== 32'h0)        begin fails++; $display("FAIL boot_commit_pc got %h want 0", pcOut); end
        checks++; if (insnValid !== 1'b0)     begin fails++; $display("FAIL first_valid got %b want 0", insnValid); end
        imemAck = 1'b1; imemData = 32'h20080005;
        tick();
        imemAck = 1'b0;
        checks++; if (insnValid !== 1'b1)        begin fails++; $display("FAIL first_rdy_valid got %b want 1", insnValid); end
        checks++; if (insnOut !== 32'h20080005)  begin fails++; $display("FAIL first_insn got %h want 20080005", insnOut); end
        checks++; if (imemReq !== 1'b0)          begin fails++; $display("FAIL first_rdy_req got %b want 0", imemReq); end
        // READY holds with no commit.
        tick(); tick();
        checks++; if (insnValid !== 1'b1 || insnOut !== 32'h20080005 || imemReq !== 1'b0) begin
            fails++; $display("FAIL ready_hold got v=%b i=%h r=%b want 1/20080005/0", insnValid, insnOut, imemReq);
        end
    endtask

    task automatic test_commit();
        commit = 1'b1; pcNext = 32'h40;
        tick();
        commit = 1'b0;
        checks++; if (pcOut !== 32'h40)    begin fails++; $display("FAIL commit_pc got %h want 40", pcOut); end
        checks++; if (insnValid !== 1'b0)  begin fails++; $display("FAIL commit_valid got %b want 0", insnValid); end
        checks++; if (imemReq !== 1'b1)    begin fails++; $display("FAIL commit_req got %b want 1", imemReq); end
        checks++; if (imemAddr !== 32'h40) begin fails++; $display("FAIL commit_addr got %h want 40", imemAddr); end
    endtask

    // Continues the fetch at 0x40: ack withheld for 5 edges, then given.
    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40 || insnValid !== 1'b0) begin
                fails++; $display("FAIL stall_%0d got r=%b a=%h v=%b want 1/40/0", i, imemReq, imemAddr, insnValid);
            end
        end
        imemAck = 1'b1; imemData = 32'h11110040;
        tick();
        imemAck = 1'b0;
        checks++; if (insnValid !== 1'b1 || insnOut !== 32'h11110040) begin
            fails++; $display("FAIL stall_done got v=%b i=%h want 1/11110040", insnValid, insnOut);
        end
`ifdef FETCH_PERF_CNT_EN
        // Second fetch since reset: the boot fetch at 0 was acked without stalling.
        checks++; if (perfStallCnt !== 32'd5) begin fails++; $display("FAIL perf_stall got %0d want 5", perfStallCnt); end
        checks++; if (perfFetchCnt !== 32'd2) begin fails++; $display("FAIL perf_fetch got %0d want 2", perfFetchCnt); end
`endif
    endtask

    task automatic test_commit_in_fetch();
        commit = 1'b1; pcNext = 32'h80;
        tick();
        pcNext = 32'h100;
        tick();
        commit = 1'b0;
        checks++; if (pcOut !== 32'h80 || imemAddr !== 32'h80 || imemReq !== 1'b1) begin
            fails++; $display("FAIL fetch_commit got pc=%h a=%h r=%b want 80/80/1", pcOut, imemAddr, imemReq);
        end
        imemAck = 1'b1; imemData = 32'hAAAA0080;
        tick();
        imemAck = 1'b0;
        checks++; if (pcOut !== 32'h80 || insnOut !== 32'hAAAA0080 || insnValid !== 1'b1) begin
            fails++; $display("FAIL fetch_commit_done got pc=%h i=%h v=%b want 80/aaaa0080/1", pcOut, insnOut, insnValid);
        end
    endtask

    task automatic test_misalign();
        commit = 1'b1; pcNext = 32'h43;
        tick();
        commit = 1'b0;
        checks++; if (misalign !== 1'b1) begin fails++; $display("FAIL misalign_set got %b want 1", misalign); end
        checks++; if (pcOut !== 32'h40 || imemAddr !== 32'h40 || imemReq !== 1'b1) begin
            fails++; $display("FAIL misalign_pc got pc=%h a=%h r=%b want 40/40/1", pcOut, imemAddr, imemReq);
        end
        imemAck = 1'b1; imemData = 32'h33330040;
        tick();
        imemAck = 1'b0;
        commit = 1'b1; pcNext = 32'h48;
        tick();
        commit = 1'b0;
        checks++; if (misalign !== 1'b1 || pcOut !== 32'h48) begin
            fails++; $display("FAIL misalign_sticky got m=%b pc=%h want 1/48", misalign, pcOut);
        end
        imemAck = 1'b1; imemData = 32'h33330048;
        tick();
        imemAck = 1'b0;
    endtask

    task automatic test_wrap();
        commit = 1'b1; pcNext = 32'hFFFFFFFC;
        tick();
        commit = 1'b0;
        checks++; if (imemAddr !== 32'hFFFFFFFC) begin fails++; $display("FAIL wrap_hi got %h want fffffffc", imemAddr); end
        imemAck = 1'b1; imemData = 32'hCAFEFFFC;
        tick();
        imemAck = 1'b0;
        commit = 1'b1; pcNext = 32'h0;
        tick();
        commit = 1'b0;
        checks++; if (pcOut !== 32'h0 || imemReq !== 1'b1) begin fails++; $display("FAIL wrap_zero got pc=%h r=%b want 0/1", pcOut, imemReq); end
        imemAck = 1'b1; imemData = 32'hCAFE0000;
        tick();
        imemAck = 1'b0;
        checks++; if (insnOut !== 32'hCAFE0000 || insnValid !== 1'b1) begin
            fails++; $display("FAIL wrap_insn got i=%h v=%b want cafe0000/1", insnOut, insnValid);
        end
    endtask

    // Single-cycle memory: ack held high, one instruction every 2 cycles.
    task automatic test_back_to_back();
        logic [31:0] addrs [2];
        addrs[0] = 32'h10; addrs[1] = 32'h14;
        imemAck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            commit = 1'b1; pcNext = addrs[i];
            tick();
            commit = 1'b0; imemData = 32'hB0000000 | addrs[i];
            checks++; if (insnValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== addrs[i]) begin
                fails++; $display("FAIL b2b_req_%0d got v=%b r=%b a=%h want 0/1/%h", i, insnValid, imemReq, imemAddr, addrs[i]);
            end
            tick();
            checks++; if (insnValid !== 1'b1 || insnOut !== (32'hB0000000 | addrs[i])) begin
                fails++; $display("FAIL b2b_rdy_%0d got v=%b i=%h want 1/%h", i, insnValid, insnOut, 32'hB0000000 | addrs[i]);
            end
        end
        imemAck = 1'b0;
    endtask

    task automatic test_rst_mid_fetch();
        commit = 1'b1; pcNext = 32'h500;
        tick();
        commit = 1'b0;
        checks++; if (imemReq !== 1'b1 || pcOut !== 32'h500) begin fails++; $display("FAIL mid_pre got r=%b pc=%h want 1/500", imemReq, pcOut); end
        rst = 1'b1;
        #1;
        checks++; if (imemReq !== 1'b0 || pcOut !== 32'h0 || insnValid !== 1'b0) begin
            fails++; $display("FAIL mid_rst got r=%b pc=%h v=%b want 0/0/0", imemReq, pcOut, insnValid);
        end
        @(negedge clk);
        imemAck = 1'b1; imemData = 32'hDEAD0500;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (insnValid !== 1'b0 || insnOut !== 32'h0 || pcOut !== 32'h0 || imemReq !== 1'b1) begin
            fails++; $display("FAIL late_ack got v=%b i=%h pc=%h r=%b want 0/0/0/1", insnValid, insnOut, pcOut, imemReq);
        end
        imemAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit();
        test_stall();
        test_commit_in_fetch();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_rst_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
